// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   STATE_W          : width of the FSM state encoding
//   state_t          : transmitter FSM states
//   PAT_DEFAULT_1011 : built-in default pattern
package seq_tx_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    SHIFT,
    GAP,
    DONE
  } state_t;

  localparam logic [3:0] PAT_DEFAULT_1011 = 4'b1011;

endpackage

// File: rtl/seq_tx_shifter.sv
// Parallel-load, shift-left register with a bit-position counter.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : load data into the register, clear the bit counter
//   shift      : shift left one bit, advance the bit counter
//   data       : parallel load value
//   msb        : current MSB (the bit being transmitted), a flop output
//   last_bit   : bit counter is at PAT_W-1
//   next_last  : bit counter is at PAT_W-2 (the next shift reaches the last bit)
module seq_tx_shifter #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] data,
  output logic             msb,
  output logic             last_bit,
  output logic             next_last
);

  localparam int unsigned BC_W = $clog2(PAT_W);

  logic [PAT_W-1:0] sreg;
  logic [BC_W-1:0]  bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sreg    <= data;
      bit_cnt <= '0;
    end else if (shift) begin
      sreg    <= {sreg[PAT_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + BC_W'(1);
    end
  end

  assign msb       = sreg[PAT_W-1];
  assign last_bit  = (bit_cnt == BC_W'(PAT_W - 1));
  assign next_last = (bit_cnt == BC_W'(PAT_W - 2));

endmodule

// File: rtl/seq_tx_pattern.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB first, repeated
// repeat_cnt times with gap_len idle cycles between repetitions.
// Optional feature macro: SEQ_TX_ABORT_EN (adds abort input / aborted output).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a transmission (sampled only while ready=1)
//   use_default  : 1 = send PAT_DEFAULT, 0 = send pattern
//   pattern      : pattern to send, bit PAT_W-1 first
//   repeat_cnt   : number of repetitions, 0 = request ignored
//   gap_len      : idle cycles between repetitions
//   abort        : (SEQ_TX_ABORT_EN) cancel transmission in SHIFT/GAP
//   aborted      : (SEQ_TX_ABORT_EN) one-cycle pulse after an abort
//   ready        : high in IDLE
//   busy         : high in SHIFT, GAP and DONE
//   out_bit      : serial data
//   out_valid    : out_bit carries pattern data
//   pat_done     : pulse with the last bit of each repetition
//   all_done     : pulse in the cycle after the final repetition
module seq_tx_pattern
  import seq_tx_pkg::*;
#(
  parameter int unsigned      PAT_W       = 4,
  parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(PAT_DEFAULT_1011),
  parameter int unsigned      CNT_W       = 8,
  parameter int unsigned      GAP_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_default,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
`ifdef SEQ_TX_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             ready,
  output logic             busy,
  output logic             out_bit,
  output logic             out_valid,
  output logic             pat_done,
  output logic             all_done
);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [CNT_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;

  logic             sh_load;
  logic             sh_shift;
  logic [PAT_W-1:0] sh_data;
  logic             last_bit;
  logic             next_last;
  logic             abort_req;

`ifdef SEQ_TX_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // The shift register is loaded with zeros whenever transmission stops, so
  // its MSB flop can drive out_bit directly and reads 0 outside SHIFT.
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = '0;
    case (state)
      IDLE: begin
        if (start && (repeat_cnt != '0)) begin
          sh_load = 1'b1;
          sh_data = use_default ? PAT_DEFAULT : pattern;
        end
      end
      SHIFT: begin
        if (abort_req) begin
          sh_load = 1'b1;
        end else if (last_bit) begin
          sh_load = 1'b1;
          if ((rep_cnt > CNT_W'(1)) && (gap_q == '0))
            sh_data = pat_q;
        end else begin
          sh_shift = 1'b1;
        end
      end
      GAP: begin
        if (!abort_req && (gap_cnt == GAP_W'(1))) begin
          sh_load = 1'b1;
          sh_data = pat_q;
        end
      end
      default: ;
    endcase
  end

  seq_tx_shifter #(
    .PAT_W(PAT_W)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .shift    (sh_shift),
    .data     (sh_data),
    .msb      (out_bit),
    .last_bit (last_bit),
    .next_last(next_last)
  );

  // Outputs are set on the edge that enters the cycle they describe, so
  // pat_done is raised one bit early (next_last) to line up with the last bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pat_q     <= '0;
      rep_cnt   <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      pat_done  <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      pat_done <= 1'b0;
      all_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (repeat_cnt != '0)) begin
            pat_q     <= sh_data;
            rep_cnt   <= repeat_cnt;
            gap_q     <= gap_len;
            state     <= SHIFT;
            ready     <= 1'b0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort_req) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end else if (last_bit) begin
            if (rep_cnt != '0)
              rep_cnt <= rep_cnt - CNT_W'(1);
            if (rep_cnt > CNT_W'(1)) begin
              if (gap_q != '0) begin
                state     <= GAP;
                gap_cnt   <= gap_q;
                out_valid <= 1'b0;
              end
            end else begin
              state     <= DONE;
              out_valid <= 1'b0;
              all_done  <= 1'b1;
            end
          end else if (next_last) begin
            pat_done <= 1'b1;
          end
        end
        GAP: begin
          if (abort_req) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else if (gap_cnt == GAP_W'(1)) begin
            state     <= SHIFT;
            out_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_TX_ABORT_EN
  always_ff @(posedge clk) begin
    if (reset)
      aborted <= 1'b0;
    else
      aborted <= abort && ((state == SHIFT) || (state == GAP));
  end
`endif

endmodule

// File: tb/tb_seq_tx_pattern.sv
// Directed self-checking bench for seq_tx_pattern (PAT_W=4, CNT_W=8, GAP_W=4).
// Captured per-cycle signals are shifted into vectors, cycle 1 ending up as
// the leftmost bit of the expected literal.
module tb_seq_tx_pattern;

  logic       clk;
  logic       reset;
  logic       start;
  logic       use_default;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       ready;
  logic       busy;
  logic       out_bit;
  logic       out_valid;
  logic       pat_done;
  logic       all_done;
`ifdef SEQ_TX_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] cap_bit, cap_vld, cap_pd, cap_ad, cap_rdy, cap_busy, cap_abt;
  int          pd_cnt, ad_cnt, vld_cnt, det_cnt;
  logic [3:0]  det_sr;

  seq_tx_pattern #(
    .PAT_W(4),
    .CNT_W(8),
    .GAP_W(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .use_default(use_default),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
`ifdef SEQ_TX_ABORT_EN
    .abort      (abort),
    .aborted    (aborted),
`endif
    .ready      (ready),
    .busy       (busy),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .pat_done   (pat_done),
    .all_done   (all_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Runs n clock edges; samples outputs #1 after each edge. Drives start,
  // reset or abort for one edge during the cycle numbers given (0 = never).
  // Also feeds out_bit into a 1011 detector.
  task automatic capture(input int n, input int start_at, input int reset_at,
                         input int abort_at);
    cap_bit = '0; cap_vld = '0; cap_pd = '0; cap_ad = '0;
    cap_rdy = '0; cap_busy = '0; cap_abt = '0;
    pd_cnt = 0; ad_cnt = 0; vld_cnt = 0; det_cnt = 0; det_sr = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      reset = 1'b0;
`ifdef SEQ_TX_ABORT_EN
      abort = 1'b0;
      cap_abt = {cap_abt[30:0], aborted};
`endif
      cap_bit  = {cap_bit[30:0], out_bit};
      cap_vld  = {cap_vld[30:0], out_valid};
      cap_pd   = {cap_pd[30:0], pat_done};
      cap_ad   = {cap_ad[30:0], all_done};
      cap_rdy  = {cap_rdy[30:0], ready};
      cap_busy = {cap_busy[30:0], busy};
      if (pat_done)  pd_cnt++;
      if (all_done)  ad_cnt++;
      if (out_valid) vld_cnt++;
      det_sr = {det_sr[2:0], out_bit};
      if (det_sr == 4'b1011) det_cnt++;
      if (c == start_at) start = 1'b1;
      if (c == reset_at) reset = 1'b1;
`ifdef SEQ_TX_ABORT_EN
      if (c == abort_at) abort = 1'b1;
`else
      if (abort_at != 0) $display("note: abort ignored in this build");
`endif
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, busy, out_bit, out_valid, pat_done, all_done} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b",
               {ready, busy, out_bit, out_valid, pat_done, all_done}, 6'b100000);
    end
`ifdef SEQ_TX_ABORT_EN
    checks++;
    if (aborted !== 1'b0) begin
      errors++;
      $display("FAIL reset_aborted: got %b want 0", aborted);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_default_single();
    use_default = 1'b1; pattern = 4'b0000; repeat_cnt = 8'd1; gap_len = 4'd0;
    start = 1'b1;
    capture(6, 0, 0, 0);
    checks++;
    if (cap_bit !== 32'b101100) begin
      errors++; $display("FAIL single_bits: got %b want %b", cap_bit[5:0], 6'b101100);
    end
    checks++;
    if (cap_vld !== 32'b111100) begin
      errors++; $display("FAIL single_valid: got %b want %b", cap_vld[5:0], 6'b111100);
    end
    checks++;
    if (cap_pd !== 32'b000100) begin
      errors++; $display("FAIL single_pat_done: got %b want %b", cap_pd[5:0], 6'b000100);
    end
    checks++;
    if (cap_ad !== 32'b000010) begin
      errors++; $display("FAIL single_all_done: got %b want %b", cap_ad[5:0], 6'b000010);
    end
    checks++;
    if (cap_rdy !== 32'b000001) begin
      errors++; $display("FAIL single_ready: got %b want %b", cap_rdy[5:0], 6'b000001);
    end
    checks++;
    if (cap_busy !== 32'b111110) begin
      errors++; $display("FAIL single_busy: got %b want %b", cap_busy[5:0], 6'b111110);
    end
  endtask

  task automatic test_gap();
    use_default = 1'b0; pattern = 4'b1100; repeat_cnt = 8'd2; gap_len = 4'd2;
    start = 1'b1;
    // Inputs change right after the start edge; the latched values must win.
    fork
      begin
        @(posedge clk);
        #2;
        pattern = 4'b0011; repeat_cnt = 8'd7; gap_len = 4'd0;
      end
    join_none
    capture(12, 0, 0, 0);
    checks++;
    if (cap_bit !== 32'b110000110000) begin
      errors++; $display("FAIL gap_bits: got %b want %b", cap_bit[11:0], 12'b110000110000);
    end
    checks++;
    if (cap_vld !== 32'b111100111100) begin
      errors++; $display("FAIL gap_valid: got %b want %b", cap_vld[11:0], 12'b111100111100);
    end
    checks++;
    if (cap_pd !== 32'b000100000100) begin
      errors++; $display("FAIL gap_pat_done: got %b want %b", cap_pd[11:0], 12'b000100000100);
    end
    checks++;
    if (cap_ad !== 32'b000000000010) begin
      errors++; $display("FAIL gap_all_done: got %b want %b", cap_ad[11:0], 12'b000000000010);
    end
    checks++;
    if (cap_busy !== 32'b111111111110) begin
      errors++; $display("FAIL gap_busy: got %b want %b", cap_busy[11:0], 12'b111111111110);
    end
  endtask

  task automatic test_back_to_back();
    use_default = 1'b1; pattern = 4'b0000; repeat_cnt = 8'd3; gap_len = 4'd0;
    start = 1'b1;
    capture(14, 0, 0, 0);
    checks++;
    if (cap_bit !== 32'b10111011101100) begin
      errors++; $display("FAIL b2b_bits: got %b want %b", cap_bit[13:0], 14'b10111011101100);
    end
    checks++;
    if (cap_vld !== 32'b11111111111100) begin
      errors++; $display("FAIL b2b_valid: got %b want %b", cap_vld[13:0], 14'b11111111111100);
    end
    checks++;
    if (cap_pd !== 32'b00010001000100) begin
      errors++; $display("FAIL b2b_pat_done: got %b want %b", cap_pd[13:0], 14'b00010001000100);
    end
    checks++;
    if (cap_ad !== 32'b00000000000010) begin
      errors++; $display("FAIL b2b_all_done: got %b want %b", cap_ad[13:0], 14'b00000000000010);
    end
    checks++;
    if (cap_rdy !== 32'b00000000000001) begin
      errors++; $display("FAIL b2b_ready: got %b want %b", cap_rdy[13:0], 14'b00000000000001);
    end
  endtask

  task automatic test_ignored_starts();
    use_default = 1'b1; pattern = 4'b0000; repeat_cnt = 8'd0; gap_len = 4'd0;
    start = 1'b1;
    capture(3, 0, 0, 0);
    checks++;
    if (cap_rdy !== 32'b111) begin
      errors++; $display("FAIL zero_rep_ready: got %b want %b", cap_rdy[2:0], 3'b111);
    end
    checks++;
    if ({cap_busy[2:0], cap_vld[2:0], cap_bit[2:0], cap_pd[2:0], cap_ad[2:0]} !== 15'b0) begin
      errors++; $display("FAIL zero_rep_activity: got %b want 0",
                         {cap_busy[2:0], cap_vld[2:0], cap_bit[2:0], cap_pd[2:0], cap_ad[2:0]});
    end
    // Second start pulse in cycle 2 of a one-repetition transmission.
    repeat_cnt = 8'd1;
    start = 1'b1;
    capture(7, 2, 0, 0);
    checks++;
    if (cap_bit !== 32'b1011000) begin
      errors++; $display("FAIL busy_start_bits: got %b want %b", cap_bit[6:0], 7'b1011000);
    end
    checks++;
    if (vld_cnt !== 4) begin
      errors++; $display("FAIL busy_start_bitcount: got %0d want 4", vld_cnt);
    end
    checks++;
    if (cap_rdy !== 32'b0000011) begin
      errors++; $display("FAIL busy_start_ready: got %b want %b", cap_rdy[6:0], 7'b0000011);
    end
  endtask

  task automatic test_reset_mid();
    use_default = 1'b1; pattern = 4'b0000; repeat_cnt = 8'd4; gap_len = 4'd0;
    start = 1'b1;
    capture(8, 0, 2, 0);
    checks++;
    if (cap_bit !== 32'b10000000) begin
      errors++; $display("FAIL midreset_bits: got %b want %b", cap_bit[7:0], 8'b10000000);
    end
    checks++;
    if (cap_vld !== 32'b11000000) begin
      errors++; $display("FAIL midreset_valid: got %b want %b", cap_vld[7:0], 8'b11000000);
    end
    checks++;
    if (cap_rdy !== 32'b00111111) begin
      errors++; $display("FAIL midreset_ready: got %b want %b", cap_rdy[7:0], 8'b00111111);
    end
    checks++;
    if ((pd_cnt !== 0) || (ad_cnt !== 0)) begin
      errors++; $display("FAIL midreset_pulses: got pd=%0d ad=%0d want 0 0", pd_cnt, ad_cnt);
    end
    // Fresh transmission after the reset.
    repeat_cnt = 8'd1;
    start = 1'b1;
    capture(6, 0, 0, 0);
    checks++;
    if ({cap_bit[5:0], cap_vld[5:0], cap_pd[5:0], cap_ad[5:0]} !== 24'b101100_111100_000100_000010) begin
      errors++; $display("FAIL after_reset_tx: got %b want %b",
                         {cap_bit[5:0], cap_vld[5:0], cap_pd[5:0], cap_ad[5:0]},
                         24'b101100_111100_000100_000010);
    end
  endtask

  task automatic test_loopback();
    use_default = 1'b1; pattern = 4'b0000; repeat_cnt = 8'd3; gap_len = 4'd1;
    start = 1'b1;
    capture(16, 0, 0, 0);
    checks++;
    if (det_cnt !== 3) begin
      errors++; $display("FAIL loopback_detections: got %0d want 3", det_cnt);
    end
    checks++;
    if ((pd_cnt !== 3) || (ad_cnt !== 1)) begin
      errors++; $display("FAIL loopback_pulses: got pd=%0d ad=%0d want 3 1", pd_cnt, ad_cnt);
    end
    checks++;
    if (cap_busy !== 32'b1111111111111110) begin
      errors++; $display("FAIL loopback_busy: got %b want %b", cap_busy[15:0], 16'b1111111111111110);
    end
  endtask

`ifdef SEQ_TX_ABORT_EN
  task automatic test_abort();
    use_default = 1'b1; pattern = 4'b0000; repeat_cnt = 8'd2; gap_len = 4'd3;
    start = 1'b1;
    capture(8, 0, 0, 5);
    checks++;
    if (cap_abt !== 32'b00000100) begin
      errors++; $display("FAIL abort_pulse: got %b want %b", cap_abt[7:0], 8'b00000100);
    end
    checks++;
    if (cap_rdy !== 32'b00000111) begin
      errors++; $display("FAIL abort_ready: got %b want %b", cap_rdy[7:0], 8'b00000111);
    end
    checks++;
    if ((cap_ad !== 32'b0) || (cap_vld !== 32'b11110000)) begin
      errors++; $display("FAIL abort_outputs: got ad=%b vld=%b want 00000000 11110000",
                         cap_ad[7:0], cap_vld[7:0]);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; use_default = 1'b0;
    pattern = '0; repeat_cnt = '0; gap_len = '0;
`ifdef SEQ_TX_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_default_single();
    test_gap();
    test_back_to_back();
    test_ignored_starts();
    test_reset_mid();
    test_loopback();
`ifdef SEQ_TX_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
